operand_tc_pipe: RTL and testbench
==================================

# operand_tc_pipe

Pipelined, parametrised operand conditioning stage for the vector Vedic (Urdhva-Tiryakbhyam) multiplier. It sits between the operand source and the multiplier array. It takes packed operands A and B plus opcode and precision. Per element it produces the magnitude (two's-complement negation of negative signed elements) and the per-element sign and result-negate flags. It generalises the combinational conditioning logic to any element width and element count, registers the result, and adds valid/ready flow control with backpressure and flush.

## Interface
- ELEM_W, default 8: base element width in bits; must be ≥ 4.
- NUM_ELEM, default 4: number of base elements; must be a multiple of 4. Total width W = ELEM_W*NUM_ELEM.
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous pipeline clear.
- in_valid, input, 1: input transaction valid.
- in_ready, output, 1: block can accept the input transaction.
- in_opcode, input, 2: 00 MUL, 01 MULH, 10 MULHU, 11 MULSU.
- in_precision, input, 2: element group size. 00 = 1 base element, 01 = 2, 10 = 4, 11 = same as 00.
- in_a, input, W: packed operand A.
- in_b, input, W: packed operand B.
- out_valid, output, 1: output transaction valid.
- out_ready, input, 1: downstream accepts the output.
- out_a_mag, output, W: conditioned operand A.
- out_b_mag, output, W: conditioned operand B.
- out_sign_a, output, NUM_ELEM: per base element, A's group was negated.
- out_sign_b, output, NUM_ELEM: per base element, B's group was negated.
- out_neg, output, NUM_ELEM: out_sign_a ^ out_sign_b; the product must be re-negated.
- out_opcode, output, 2: opcode of the transaction, passed through.
- out_precision, output, 2: precision of the transaction, passed through.

## Operation
- **Group width G.** G = ELEM_W × (1, 2, 4) for precision (00/11, 01, 10). Groups are aligned to multiples of G. There are W/G independent groups.
- **Signedness.** A is signed for opcodes 00, 01, 11. B is signed for opcodes 00, 01. An unsigned operand passes through unchanged and its sign flags are 0.
- **Signed group.**
  - If the group MSB is 1, the group is replaced by its G-bit two's complement (invert, then +1 with carry confined to the group).
  - Every base element inside that group gets its sign flag set.
  - The most-negative value maps to itself; it is interpreted downstream as the unsigned magnitude 2^(G-1).
- **Carry confinement.** Carry never crosses a group boundary.
- **Stages (default build).**
  - S1 registers the inputs and the per-element sign selects.
  - S2 registers the negated operands, the flags and the passthroughs.
- **Flow control.** A stage holds its contents while it is valid and the next stage cannot take them.
  - s2_take = !s2_valid | out_ready
  - s1_take = !s1_valid | s2_take
  - in_ready = s1_take & !flush
- **Acceptance.** A transaction is accepted on an edge where in_valid & in_ready. Throughput is 1 transaction per cycle. Order is preserved and there is no loss or duplication.
- **Output stability.** While out_valid & !out_ready, all out_* signals are held stable.
- **Flush.** On the edge where flush = 1, s1_valid and s2_valid clear. No input is accepted in that cycle. Data registers may keep stale values.
- **Simultaneous out_ready and flush.** The output handshake completes and the pipeline then empties.
- **Reset.** While rst_n = 0, every valid flag and every out_* signal is 0, including in_ready. After rst_n deasserts, in_ready = 1.
- **Reset mid-operation.** In-flight transactions are discarded.

## Timing
- A transaction accepted on edge k is captured in S1 at edge k, moves to S2 at edge k+1, and out_valid is high from edge k+1.
- Latency from acceptance to out_valid: 2 cycles. The earliest downstream handshake is on edge k+2.
- in_ready is combinational from out_ready, flush and the stage valid flags. There is no combinational path from in_a or in_b to any output.
- Critical path: the G-bit negate chain, longest at precision 10.

## Configuration
- Macro: OPERAND_TC_PIPE_SINGLE_STAGE_EN.
- **Defined.**
  - S1 is removed; the negation is computed from the inputs and registered directly into S2.
  - Latency is 1 cycle: out_valid is high from edge k.
  - in_ready = s2_take & !flush.
- **Undefined.** The 2-stage pipeline described above.
- All other behaviour is identical in both builds.

## Test plan
All values are for the default parameters (W = 32, ELEM_W = 8, NUM_ELEM = 4).

1. MUL, precision 00, a=0x80FF017F, b=0x01020304 -> out_a_mag=0x8001017F, out_b_mag=0x01020304, out_sign_a=1100, out_sign_b=0000, out_neg=1100, out_valid high 1 edge after acceptance.
2. MULHU, precision 10, a=0xFFFFFFFF, b=0x80000000 -> both operands unchanged, all sign flags and out_neg 0000.
3. MULSU, precision 01, a=0xFFFE0003, b=0x8000FFFF -> out_a_mag=0x00020003, out_sign_a=1100, out_b_mag=0x8000FFFF, out_sign_b=0000, out_neg=1100.
4. MUL, precision 10, a=0xFFFFFFFF, b=0xFFFFFFFE -> out_a_mag=0x00000001, out_b_mag=0x00000002, out_sign_a=out_sign_b=1111, out_neg=0000. Repeat with precision 11 and a=0x80808080 -> out_a_mag=0x80808080, out_sign_a=1111.
5. Backpressure: stream 5 back-to-back transactions, hold out_ready=0 for 4 cycles -> in_ready drops after 2 acceptances, outputs stay stable, all 5 emerge in order once out_ready=1, one per cycle.
6. Flush asserted with both stages full, then rst_n pulsed low mid-stream -> out_valid=0 next edge, no stale transaction emitted, in_ready=0 during flush and reset, all outputs 0 during reset.

Source files
------------

// File: rtl/operand_tc_pipe_if.sv
// Handshake and operand bus for operand_tc_pipe.
// The master side drives operands, flush and out_ready; the slave side is the conditioning stage.
interface operand_tc_pipe_if #(
  parameter int unsigned ELEM_W   = 8,
  parameter int unsigned NUM_ELEM = 4
);
  localparam int unsigned W = ELEM_W * NUM_ELEM;

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_opcode;
  logic [1:0]          in_precision;
  logic [W-1:0]        in_a;
  logic [W-1:0]        in_b;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_a_mag;
  logic [W-1:0]        out_b_mag;
  logic [NUM_ELEM-1:0] out_sign_a;
  logic [NUM_ELEM-1:0] out_sign_b;
  logic [NUM_ELEM-1:0] out_neg;
  logic [1:0]          out_opcode;
  logic [1:0]          out_precision;

  modport master (
    output flush, in_valid, in_opcode, in_precision, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a_mag, out_b_mag, out_sign_a, out_sign_b,
           out_neg, out_opcode, out_precision
  );

  modport slave (
    input  flush, in_valid, in_opcode, in_precision, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a_mag, out_b_mag, out_sign_a, out_sign_b,
           out_neg, out_opcode, out_precision
  );
endinterface

// File: rtl/operand_tc_pipe.sv
// Operand conditioning for the vector Vedic multiplier: per-group magnitude and sign flags.
// OPERAND_TC_PIPE_SINGLE_STAGE_EN collapses the two-stage pipeline into one stage.
module operand_tc_pipe #(
  parameter int unsigned ELEM_W   = 8,
  parameter int unsigned NUM_ELEM = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  operand_tc_pipe_if.slave   bus
);
  localparam int unsigned W = ELEM_W * NUM_ELEM;

  // Number of base elements per group for a precision code.
  function automatic int unsigned grp_elems(input logic [1:0] prec);
    case (prec)
      2'b01:   grp_elems = 2;
      2'b10:   grp_elems = 4;
      default: grp_elems = 1;
    endcase
  endfunction

  // Per-element negate select: the MSB of the enclosing group, if the operand is signed.
  function automatic logic [NUM_ELEM-1:0] sign_sel(input logic [W-1:0] x,
                                                   input logic       en,
                                                   input logic [1:0] prec);
    int unsigned span;
    int unsigned top;
    sign_sel = '0;
    span     = grp_elems(prec);
    for (int unsigned i = 0; i < NUM_ELEM; i++) begin
      top         = i | (span - 1);
      sign_sel[i] = en & x[top*ELEM_W + ELEM_W - 1];
    end
  endfunction

  // Group-wise two's complement; the +1 carry restarts at every group boundary.
  function automatic logic [W-1:0] cond_neg(input logic [W-1:0]        x,
                                            input logic [NUM_ELEM-1:0] sel,
                                            input logic [1:0]          prec);
    logic [ELEM_W:0] sum;
    logic            cy;
    int unsigned     span;
    cond_neg = x;
    cy       = 1'b0;
    span     = grp_elems(prec);
    for (int unsigned i = 0; i < NUM_ELEM; i++) begin
      if ((i & (span - 1)) == 0) cy = 1'b1;
      sum = {1'b0, ~x[i*ELEM_W +: ELEM_W]} + {{ELEM_W{1'b0}}, cy};
      cy  = sum[ELEM_W];
      if (sel[i]) cond_neg[i*ELEM_W +: ELEM_W] = sum[ELEM_W-1:0];
    end
  endfunction

  logic s2_take_c;
  logic in_ready_c;
  logic accept_c;

  logic                s2_valid_q,   s2_valid_d;
  logic [W-1:0]        s2_a_mag_q,   s2_a_mag_d;
  logic [W-1:0]        s2_b_mag_q,   s2_b_mag_d;
  logic [NUM_ELEM-1:0] s2_sign_a_q,  s2_sign_a_d;
  logic [NUM_ELEM-1:0] s2_sign_b_q,  s2_sign_b_d;
  logic [NUM_ELEM-1:0] s2_neg_q,     s2_neg_d;
  logic [1:0]          s2_opcode_q,  s2_opcode_d;
  logic [1:0]          s2_prec_q,    s2_prec_d;

  // Sources feeding S2: the S1 registers, or the raw inputs in the single-stage build.
  logic                src_valid_c;
  logic                src_load_c;
  logic [W-1:0]        src_a_c;
  logic [W-1:0]        src_b_c;
  logic [NUM_ELEM-1:0] src_sel_a_c;
  logic [NUM_ELEM-1:0] src_sel_b_c;
  logic [1:0]          src_opcode_c;
  logic [1:0]          src_prec_c;

`ifndef OPERAND_TC_PIPE_SINGLE_STAGE_EN
  logic s1_take_c;

  logic                s1_valid_q,  s1_valid_d;
  logic [W-1:0]        s1_a_q,      s1_a_d;
  logic [W-1:0]        s1_b_q,      s1_b_d;
  logic [NUM_ELEM-1:0] s1_sel_a_q,  s1_sel_a_d;
  logic [NUM_ELEM-1:0] s1_sel_b_q,  s1_sel_b_d;
  logic [1:0]          s1_opcode_q, s1_opcode_d;
  logic [1:0]          s1_prec_q,   s1_prec_d;

  // Flow control: a stage takes new data when empty or when its successor drains it.
  always_comb begin
    s2_take_c  = ~s2_valid_q | bus.out_ready;
    s1_take_c  = ~s1_valid_q | s2_take_c;
    in_ready_c = s1_take_c & ~bus.flush & rst_n;
    accept_c   = bus.in_valid & in_ready_c;
  end

  // S1 captures operands and the per-element sign selects.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_sel_a_d  = s1_sel_a_q;
    s1_sel_b_d  = s1_sel_b_q;
    s1_opcode_d = s1_opcode_q;
    s1_prec_d   = s1_prec_q;
    if (s1_take_c) s1_valid_d = accept_c;
    if (accept_c) begin
      s1_a_d      = bus.in_a;
      s1_b_d      = bus.in_b;
      s1_sel_a_d  = sign_sel(bus.in_a, bus.in_opcode != 2'b10, bus.in_precision);
      s1_sel_b_d  = sign_sel(bus.in_b, ~bus.in_opcode[1], bus.in_precision);
      s1_opcode_d = bus.in_opcode;
      s1_prec_d   = bus.in_precision;
    end
    if (bus.flush) s1_valid_d = 1'b0;
  end

  always_comb begin
    src_valid_c  = s1_valid_q;
    src_load_c   = s2_take_c & s1_valid_q;
    src_a_c      = s1_a_q;
    src_b_c      = s1_b_q;
    src_sel_a_c  = s1_sel_a_q;
    src_sel_b_c  = s1_sel_b_q;
    src_opcode_c = s1_opcode_q;
    src_prec_c   = s1_prec_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sel_a_q  <= '0;
      s1_sel_b_q  <= '0;
      s1_opcode_q <= '0;
      s1_prec_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_sel_a_q  <= s1_sel_a_d;
      s1_sel_b_q  <= s1_sel_b_d;
      s1_opcode_q <= s1_opcode_d;
      s1_prec_q   <= s1_prec_d;
    end
  end
`else
  always_comb begin
    s2_take_c  = ~s2_valid_q | bus.out_ready;
    in_ready_c = s2_take_c & ~bus.flush & rst_n;
    accept_c   = bus.in_valid & in_ready_c;
  end

  // Selects and negation computed straight from the inputs.
  always_comb begin
    src_valid_c  = accept_c;
    src_load_c   = accept_c;
    src_a_c      = bus.in_a;
    src_b_c      = bus.in_b;
    src_sel_a_c  = sign_sel(bus.in_a, bus.in_opcode != 2'b10, bus.in_precision);
    src_sel_b_c  = sign_sel(bus.in_b, ~bus.in_opcode[1], bus.in_precision);
    src_opcode_c = bus.in_opcode;
    src_prec_c   = bus.in_precision;
  end
`endif

  // S2 holds the conditioned result until the downstream handshake.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_a_mag_d  = s2_a_mag_q;
    s2_b_mag_d  = s2_b_mag_q;
    s2_sign_a_d = s2_sign_a_q;
    s2_sign_b_d = s2_sign_b_q;
    s2_neg_d    = s2_neg_q;
    s2_opcode_d = s2_opcode_q;
    s2_prec_d   = s2_prec_q;
    if (s2_take_c) s2_valid_d = src_valid_c;
    if (src_load_c) begin
      s2_a_mag_d  = cond_neg(src_a_c, src_sel_a_c, src_prec_c);
      s2_b_mag_d  = cond_neg(src_b_c, src_sel_b_c, src_prec_c);
      s2_sign_a_d = src_sel_a_c;
      s2_sign_b_d = src_sel_b_c;
      s2_neg_d    = src_sel_a_c ^ src_sel_b_c;
      s2_opcode_d = src_opcode_c;
      s2_prec_d   = src_prec_c;
    end
    if (bus.flush) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_a_mag_q  <= '0;
      s2_b_mag_q  <= '0;
      s2_sign_a_q <= '0;
      s2_sign_b_q <= '0;
      s2_neg_q    <= '0;
      s2_opcode_q <= '0;
      s2_prec_q   <= '0;
    end else begin
      s2_valid_q  <= s2_valid_d;
      s2_a_mag_q  <= s2_a_mag_d;
      s2_b_mag_q  <= s2_b_mag_d;
      s2_sign_a_q <= s2_sign_a_d;
      s2_sign_b_q <= s2_sign_b_d;
      s2_neg_q    <= s2_neg_d;
      s2_opcode_q <= s2_opcode_d;
      s2_prec_q   <= s2_prec_d;
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = s2_valid_q;
  assign bus.out_a_mag     = s2_a_mag_q;
  assign bus.out_b_mag     = s2_b_mag_q;
  assign bus.out_sign_a    = s2_sign_a_q;
  assign bus.out_sign_b    = s2_sign_b_q;
  assign bus.out_neg       = s2_neg_q;
  assign bus.out_opcode    = s2_opcode_q;
  assign bus.out_precision = s2_prec_q;
endmodule

// File: tb/tb_operand_tc_pipe.sv
// Directed and randomized bench for operand_tc_pipe with a group-arithmetic reference model.
module tb_operand_tc_pipe;
  localparam int unsigned EW = 8;
  localparam int unsigned NE = 4;
`ifdef OPERAND_TC_PIPE_SINGLE_STAGE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [1:0]  pr;
  } txn_t;
  // {a_mag, b_mag, sign_a, sign_b, neg, opcode, precision}
  typedef logic [79:0] res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  operand_tc_pipe_if #(.ELEM_W(EW), .NUM_ELEM(NE)) bus ();
  operand_tc_pipe #(.ELEM_W(EW), .NUM_ELEM(NE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  txn_t pend[$];
  res_t pend_exp[$];
  res_t sb[$];
  bit   last_acc, last_hs, last_ov, last_ir, prev_stall;
  res_t held;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic res_t outv();
    return {bus.out_a_mag, bus.out_b_mag, bus.out_sign_a, bus.out_sign_b,
            bus.out_neg, bus.out_opcode, bus.out_precision};
  endfunction

  // Reference: split into groups numerically, replace negative signed groups by 2^G - v.
  function automatic res_t model(input txn_t t);
    longint unsigned mask, va, vb, am, bm;
    logic [3:0] sa, sb_f;
    int ge, g;
    am = 0; bm = 0; sa = '0; sb_f = '0;
    ge = (t.pr == 2'b01) ? 2 : (t.pr == 2'b10) ? 4 : 1;
    g = 8 * ge;
    mask = (64'd1 << g) - 64'd1;
    for (int k = 0; k < 4 / ge; k++) begin
      va = (64'(t.a) >> (k * g)) & mask;
      vb = (64'(t.b) >> (k * g)) & mask;
      if (t.op != 2'b10 && ((va >> (g - 1)) & 64'd1) == 64'd1) begin
        va = ((64'd1 << g) - va) & mask;
        for (int e = k * ge; e < (k + 1) * ge; e++) sa[e] = 1'b1;
      end
      if ((t.op == 2'b00 || t.op == 2'b01) && ((vb >> (g - 1)) & 64'd1) == 64'd1) begin
        vb = ((64'd1 << g) - vb) & mask;
        for (int e = k * ge; e < (k + 1) * ge; e++) sb_f[e] = 1'b1;
      end
      am = am | (va << (k * g));
      bm = bm | (vb << (k * g));
    end
    return {am[31:0], bm[31:0], sa, sb_f, sa ^ sb_f, t.op, t.pr};
  endfunction

  function automatic txn_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] op, input logic [1:0] pr);
    txn_t t;
    t.a = a; t.b = b; t.op = op; t.pr = pr;
    return t;
  endfunction

  task automatic send_exp(input txn_t t, input res_t e);
    pend.push_back(t);
    pend_exp.push_back(e);
  endtask

  task automatic send_m(input txn_t t);
    send_exp(t, model(t));
  endtask

  // One clock: drive queued input, sample at negedge, score handshakes, advance.
  task automatic cycle();
    if (pend.size() > 0) begin
      bus.in_valid = 1'b1;
      bus.in_a = pend[0].a; bus.in_b = pend[0].b;
      bus.in_opcode = pend[0].op; bus.in_precision = pend[0].pr;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_a = $urandom; bus.in_b = $urandom;
      bus.in_opcode = 2'($urandom); bus.in_precision = 2'($urandom);
    end
    @(negedge clk);
    last_acc = bus.in_valid && bus.in_ready;
    last_hs  = bus.out_valid && bus.out_ready;
    last_ov  = bus.out_valid;
    last_ir  = bus.in_ready;
    if (prev_stall) chk("hold_stable", outv(), held);
    if (sb.size() == 0) chk("idle_out_valid", 80'(bus.out_valid), 80'(0));
    else if (last_hs) chk("out_data", outv(), sb.pop_front());
    if (bus.flush) sb.delete();
    if (last_acc) begin
      sb.push_back(pend_exp.pop_front());
      void'(pend.pop_front());
    end
    prev_stall = bus.out_valid && !bus.out_ready && !bus.flush;
    held = outv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && (sb.size() + pend.size()) > 0; n++) cycle();
    chk("drain_empty", 80'(sb.size() + pend.size()), 80'(0));
  endtask

  initial begin
    int acc, hs;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.in_a = '0; bus.in_b = '0; bus.in_opcode = '0; bus.in_precision = '0;
    prev_stall = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 80'(bus.in_ready), 80'(0));
    chk("rst_out_valid", 80'(bus.out_valid), 80'(0));
    chk("rst_outputs", outv(), 80'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 80'(bus.in_ready), 80'(1));
    @(posedge clk); #1;

    // 1: MUL prec 00 with latency check
    send_exp(mk(32'h80FF017F, 32'h01020304, 2'b00, 2'b00),
             {32'h8001017F, 32'h01020304, 4'b1100, 4'b0000, 4'b1100, 2'b00, 2'b00});
    cycle();
    chk("t1_accept", 80'(last_acc), 80'(1));
    cycle();
    chk("t1_lat_edge1", 80'(last_ov), 80'(LAT == 1));
    cycle();
    chk("t1_lat_edge2", 80'(last_ov), 80'(LAT == 2));
    drain();

    // 2-4: directed opcode/precision cases
    send_exp(mk(32'hFFFFFFFF, 32'h80000000, 2'b10, 2'b10),
             {32'hFFFFFFFF, 32'h80000000, 4'b0000, 4'b0000, 4'b0000, 2'b10, 2'b10});
    send_exp(mk(32'hFFFE0003, 32'h8000FFFF, 2'b11, 2'b01),
             {32'h00020003, 32'h8000FFFF, 4'b1100, 4'b0000, 4'b1100, 2'b11, 2'b01});
    send_exp(mk(32'hFFFFFFFF, 32'hFFFFFFFE, 2'b00, 2'b10),
             {32'h00000001, 32'h00000002, 4'b1111, 4'b1111, 4'b0000, 2'b00, 2'b10});
    send_exp(mk(32'h80808080, 32'h00000001, 2'b00, 2'b11),
             {32'h80808080, 32'h00000001, 4'b1111, 4'b0000, 4'b1111, 2'b00, 2'b11});
    drain();

    // 5: backpressure
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_m(mk($urandom, $urandom, 2'($urandom), 2'($urandom)));
    acc = 0;
    repeat (4) begin cycle(); acc += int'(last_acc); end
    chk("bp_accepts", 80'(acc), 80'(LAT));
    chk("bp_in_ready_low", 80'(last_ir), 80'(0));
    bus.out_ready = 1'b1;
    hs = 0;
    repeat (5) begin cycle(); hs += int'(last_hs); end
    chk("bp_burst", 80'(hs), 80'(5));
    drain();

    // 6a: flush with both stages full, completing an output handshake in the same cycle
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_m(mk($urandom, $urandom, 2'($urandom), 2'($urandom)));
    repeat (4) cycle();
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    cycle();
    chk("flush_in_ready", 80'(last_ir), 80'(0));
    chk("flush_hs", 80'(last_hs), 80'(1));
    bus.flush = 1'b0;
    cycle();
    chk("flush_out_valid", 80'(last_ov), 80'(0));
    drain();

    // 6b: reset mid-stream
    for (int i = 0; i < 4; i++) send_m(mk($urandom, $urandom, 2'($urandom), 2'($urandom)));
    repeat (2) cycle();
    rst_n = 1'b0;
    sb.delete(); pend.delete(); pend_exp.delete();
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 80'(bus.in_ready), 80'(0));
    chk("midrst_out_valid", 80'(bus.out_valid), 80'(0));
    chk("midrst_outputs", outv(), 80'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    prev_stall = 1'b0;

    // Randomized traffic with stalls and occasional flush
    for (int n = 0; n < 400; n++) begin
      bus.out_ready = ($urandom % 4) != 0;
      bus.flush = ($urandom % 60) == 0;
      if (pend.size() == 0 && ($urandom % 4) != 0)
        send_m(mk($urandom, $urandom, 2'($urandom), 2'($urandom)));
      cycle();
    end
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
